// File: rtl/spi_serial_rx.sv
// SPI slave receiver: synchronised SCK/CS/MOSI, fixed-length frame capture with bad-length error pulse.
// Optional 8-bit saturating error counter output enabled by defining SPI_RX_ERR_CNT_EN.
module spi_serial_rx #(
  parameter int DATA_W      = 48,
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_EDGE = 1,
  parameter int MSB_FIRST   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_out,
  output logic [DATA_W-1:0] spi_rdata,
  output logic              spi_rvalid,
  output logic              spi_err,
  output logic              busy
`ifdef SPI_RX_ERR_CNT_EN
  , output logic [7:0]      err_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(DATA_W + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECV} state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_sck_prev, r_cs_prev;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [DATA_W-1:0]      r_shift, r_rdata;
  logic                   r_rvalid, r_err, r_busy;

  logic w_sck, w_cs, w_mosi, w_sample, w_cs_fall, w_cs_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_cs_prev   <= 1'b1;
      r_fill      <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_clk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_out};
      r_sck_prev  <= w_sck;
      r_cs_prev   <= w_cs;
      r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_sck     = r_sck_sync[SYNC_STAGES-1];
  assign w_cs      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sample  = (SAMPLE_EDGE != 0) ? (r_sck_prev & ~w_sck) : (~r_sck_prev & w_sck);
  assign w_cs_fall = r_cs_prev & ~w_cs;
  assign w_cs_rise = ~r_cs_prev & w_cs;

  // WAIT_IDLE only trusts CS once the chain holds real pin samples; the reset
  // value of 1 would otherwise let a frame already in progress slip through.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= WAIT_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        WAIT_IDLE: if (r_fill[SYNC_STAGES-1] && w_cs) r_state <= IDLE;
        IDLE: if (w_cs_fall) begin
          r_state <= RECV;
          r_cnt   <= '0;
          r_shift <= '0;
          r_busy  <= 1'b1;
        end
        RECV: begin
          if (w_cs_rise) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (r_cnt == CNT_FULL) begin
              r_rdata  <= r_shift;
              r_rvalid <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end else if (w_sample && !w_cs && r_cnt != CNT_OVR) begin
            r_cnt <= r_cnt + 1'b1;
            if (MSB_FIRST != 0) r_shift <= {r_shift[DATA_W-2:0], w_mosi};
            else                r_shift <= {w_mosi, r_shift[DATA_W-1:1]};
          end
        end
        default: begin
          r_state <= WAIT_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign spi_rdata  = r_rdata;
  assign spi_rvalid = r_rvalid;
  assign spi_err    = r_err;
  assign busy       = r_busy;

`ifdef SPI_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  always_ff @(posedge clk) begin
    if (rst)                             r_err_cnt <= '0;
    else if (r_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end
  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_spi_serial_rx.sv
// Directed bench for spi_serial_rx: default 48-bit instance plus a 16-bit LSB-first rising-edge instance.
// Expected frame outcomes are queued at CS rise and matched against observed pulses.
module tb_spi_serial_rx;
  localparam int S = 2;
  localparam int H = 10;
  localparam logic [63:0] FRAME1 = 64'h0000_A5A5_0F0F_1234;
  localparam logic [63:0] FRAME2 = 64'h0000_1234_5678_9ABC;

  typedef struct {
    bit          src;
    logic        is_err;
    logic [63:0] data;
    int          cyc;
  } ev_t;

  logic clk, rst;
  logic a_sck, a_cs, a_mosi, a_rvalid, a_err, a_busy;
  logic [47:0] a_rdata;
  logic b_sck, b_cs, b_mosi, b_rvalid, b_err, b_busy;
  logic [15:0] b_rdata;
`ifdef SPI_RX_ERR_CNT_EN
  logic [7:0] a_err_cnt, b_err_cnt;
`endif

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  bit  both_hi = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  spi_serial_rx dut_a (
    .clk(clk), .rst(rst), .spi_clk(a_sck), .spi_cs(a_cs), .spi_out(a_mosi),
    .spi_rdata(a_rdata), .spi_rvalid(a_rvalid), .spi_err(a_err), .busy(a_busy)
`ifdef SPI_RX_ERR_CNT_EN
    , .err_cnt(a_err_cnt)
`endif
  );

  spi_serial_rx #(.DATA_W(16), .SYNC_STAGES(2), .SAMPLE_EDGE(0), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .spi_clk(b_sck), .spi_cs(b_cs), .spi_out(b_mosi),
    .spi_rdata(b_rdata), .spi_rvalid(b_rvalid), .spi_err(b_err), .busy(b_busy)
`ifdef SPI_RX_ERR_CNT_EN
    , .err_cnt(b_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_rvalid === 1'b1 || a_err === 1'b1) obs_q.push_back('{1'b0, a_err, 64'(a_rdata), cyc});
    if (b_rvalid === 1'b1 || b_err === 1'b1) obs_q.push_back('{1'b1, b_err, 64'(b_rdata), cyc});
    if ((a_rvalid === 1'b1 && a_err === 1'b1) || (b_rvalid === 1'b1 && b_err === 1'b1)) both_hi <= 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input bit src, input logic is_err, input logic [63:0] data, input int rise);
    ev_t e, o;
    int  t;
    exp_q.push_back('{src, is_err, data, rise});
    t = 0;
    while (obs_q.size() == 0 && t < 50) begin
      tick(1);
      t++;
    end
    e = exp_q.pop_front();
    chk("pulse_seen", 64'(obs_q.size() != 0), 64'd1);
    if (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      chk("pulse_src", 64'(o.src), 64'(e.src));
      chk("pulse_is_err", 64'(o.is_err), 64'(e.is_err));
      chk("rdata", o.data, e.data);
      chk("latency", 64'(o.cyc - e.cyc), 64'(S + 1));
    end
  endtask

  task automatic a_bit(input logic b, input bit drop);
    a_sck = 1'b1;
    a_mosi = b;
    tick(H);
    if (drop) begin
      a_sck = 1'b0;
      tick(H);
    end
  endtask

  // coincide: the last falling SCK edge lands together with CS rising
  task automatic frame_a(input int n, input logic [63:0] d, input bit coincide,
                         input logic exp_err, input logic [63:0] exp_data);
    int rise;
    a_cs = 1'b0;
    tick(H);
    for (int i = n - 1; i >= 0; i--) begin
      a_bit(d[i], !(coincide && i == 0));
      if (i == n - 1) chk("a_busy_frame", 64'(a_busy), 64'd1);
    end
    a_cs = 1'b1;
    a_sck = 1'b0;
    rise = cyc;
    expect_ev(1'b0, exp_err, exp_data, rise);
    tick(4);
  endtask

  task automatic frame_b(input logic [63:0] d);
    int rise;
    b_cs = 1'b0;
    tick(H);
    for (int i = 0; i < 16; i++) begin
      b_mosi = d[i];
      tick(H);
      b_sck = 1'b1;
      tick(H);
      b_sck = 1'b0;
    end
    tick(H);
    b_cs = 1'b1;
    rise = cyc;
    expect_ev(1'b1, 1'b0, d, rise);
    tick(4);
  endtask

  initial begin
    rst = 1'b1;
    a_sck = 1'b0; a_cs = 1'b1; a_mosi = 1'b0;
    b_sck = 1'b0; b_cs = 1'b1; b_mosi = 1'b0;
    tick(3);
    chk("reset_rdata", 64'(a_rdata), 64'd0);
    chk("reset_rvalid", 64'(a_rvalid), 64'd0);
    chk("reset_err", 64'(a_err), 64'd0);
    chk("reset_busy", 64'(a_busy), 64'd0);
    chk("reset_b_rdata", 64'(b_rdata), 64'd0);
`ifdef SPI_RX_ERR_CNT_EN
    chk("reset_err_cnt", 64'(a_err_cnt), 64'd0);
`endif
    rst = 1'b0;
    tick(10);

    frame_a(48, FRAME1, 1'b0, 1'b0, FRAME1);
    frame_a(47, 64'h0000_5555_AAAA_1234, 1'b0, 1'b1, FRAME1);
    frame_a(49, 64'h0001_FFFF_0000_AAAA, 1'b0, 1'b1, FRAME1);
    chk("rdata_held", 64'(a_rdata), FRAME1);
`ifdef SPI_RX_ERR_CNT_EN
    chk("err_cnt_2", 64'(a_err_cnt), 64'd2);
`endif

    frame_a(48, 64'h0000_FFFF_FFFF_FFFF, 1'b1, 1'b1, FRAME1);
`ifdef SPI_RX_ERR_CNT_EN
    chk("err_cnt_3", 64'(a_err_cnt), 64'd3);
`endif

    for (int k = 0; k < 300; k++) frame_a(1, 64'd1, 1'b0, 1'b1, FRAME1);
`ifdef SPI_RX_ERR_CNT_EN
    chk("err_cnt_sat", 64'(a_err_cnt), 64'd255);
`endif

    // reset in the middle of a frame, CS kept low through the rest of it
    a_cs = 1'b0;
    tick(H);
    for (int i = 47; i >= 28; i--) a_bit(FRAME2[i], 1'b1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("midrst_rdata", 64'(a_rdata), 64'd0);
    chk("midrst_busy", 64'(a_busy), 64'd0);
`ifdef SPI_RX_ERR_CNT_EN
    chk("midrst_err_cnt", 64'(a_err_cnt), 64'd0);
`endif
    for (int i = 27; i >= 0; i--) a_bit(FRAME2[i], 1'b1);
    chk("midrst_busy_end", 64'(a_busy), 64'd0);
    a_cs = 1'b1;
    tick(20);
    chk("midrst_no_pulse", 64'(obs_q.size()), 64'd0);
    frame_a(48, FRAME2, 1'b0, 1'b0, FRAME2);

    frame_b(64'h0001);
    frame_b(64'hBEEF);
    chk("b_busy_idle", 64'(b_busy), 64'd0);

    tick(20);
    chk("no_extra_pulse", 64'(obs_q.size()), 64'd0);
    chk("rvalid_err_exclusive", 64'(both_hi), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_serial_rx.md
SPI_SERIAL_RX -- requirements
Module: spi_serial_rx

Interface
REQ-001 Parameters SHALL be as follows, one per line (name, default, meaning):
- DATA_W, 48, frame length in bits, legal range 8..64.
- SYNC_STAGES, 2, synchroniser depth on every SPI input, legal range 2..3.
- SAMPLE_EDGE, 1, SCK edge on which MOSI is sampled: 1 = falling, 0 = rising.
- MSB_FIRST, 1, bit order: 1 = first received bit lands in bit DATA_W-1, 0 = first bit lands in bit 0.
REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk, in, 1, system reference clock; the only clock in the block.
- rst, in, 1, reset, synchronous to clk, active-high.
- spi_clk, in, 1, SPI SCK from master, asynchronous.
- spi_cs, in, 1, SPI chip select from master, active-low, asynchronous.
- spi_out, in, 1, MOSI serial data from master, asynchronous.
- spi_rdata, out, DATA_W, last good frame, held until the next good frame.
- spi_rvalid, out, 1, one-cycle pulse when spi_rdata updates.
- spi_err, out, 1, one-cycle pulse when a frame has a bad bit count.
- busy, out, 1, high while state is RECV.

Function
REQ-003 spi_clk, spi_cs and spi_out SHALL each pass through a SYNC_STAGES-deep flip-flop chain before any use; all logic SHALL use only the synchronised copies.
REQ-004 A sample event SHALL be a 1-cycle detection of the selected SCK edge, made by comparing the last two synchronised SCK values.
REQ-005 The FSM SHALL have exactly 3 states: WAIT_IDLE, IDLE and RECV.
REQ-006 WAIT_IDLE -> IDLE SHALL occur when synchronised CS = 1.
REQ-007 IDLE -> RECV SHALL occur on a synchronised CS falling edge; on this transition the bit counter SHALL clear to 0 and the shift register SHALL clear to 0.
REQ-008 In RECV, each sample event SHALL shift synchronised MOSI into the shift register in MSB_FIRST order and increment the bit counter.
REQ-009 The bit counter SHALL be $clog2(DATA_W+2) bits wide and SHALL saturate at DATA_W+1 (overrun marker).
REQ-010 In RECV, shifting SHALL stop once the counter exceeds DATA_W.
REQ-011 RECV -> IDLE SHALL occur on a synchronised CS rising edge; the frame outcome SHALL be decided on that same edge:
- If count == DATA_W, spi_rdata SHALL load the shift register and spi_rvalid SHALL pulse for exactly 1 cycle.
- Otherwise (short frame or overrun), spi_err SHALL pulse for exactly 1 cycle and spi_rdata SHALL be unchanged.
REQ-012 spi_rvalid and spi_err SHALL never be high in the same cycle.
REQ-013 Latency from the spi_cs pin rising to the spi_rvalid/spi_err pulse SHALL be SYNC_STAGES+1 clk cycles.
REQ-014 A sample event in the same cycle as the CS rising edge SHALL be ignored, and the bit count SHALL be evaluated without it.
REQ-015 Sample events while synchronised CS = 1, or in IDLE or WAIT_IDLE, SHALL be ignored.
REQ-016 Legal operation SHALL require an SCK half-period of at least SYNC_STAGES+2 clk cycles; behaviour below that limit is undefined but SHALL NOT lock up the FSM.

Reset
REQ-017 When rst = 1 at a clk edge:
- State SHALL go to WAIT_IDLE.
- The counter and shift register SHALL clear to 0.
- spi_rdata SHALL be 0; spi_rvalid, spi_err and busy SHALL be 0.
- Synchroniser chains SHALL load SCK = 0 and CS = 1.
REQ-018 A reset during RECV SHALL discard the frame with no spi_rvalid or spi_err pulse.
REQ-019 If CS is already low when rst deasserts, the block SHALL ignore that frame and stay in WAIT_IDLE until CS goes high.

Configuration
REQ-020 The macro SPI_RX_ERR_CNT_EN SHALL control an error counter:
- When defined, the block SHALL add output err_cnt[7:0].
- err_cnt SHALL increment on each spi_err pulse and saturate at 255.
- err_cnt SHALL reset to 0 on rst.
- When the macro is not defined, err_cnt SHALL be absent and no counter logic SHALL be synthesised.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Default parameters, 48-bit frame 0xA5A5_0F0F_1234, SCK period 20 clk -> spi_rdata = 0xA5A5_0F0F_1234, one spi_rvalid pulse SYNC_STAGES+1 cycles after CS rises.
- 47-bit frame, then 49-bit frame -> two spi_err pulses, spi_rdata unchanged, err_cnt = 2 when the macro is defined.
- DATA_W=16, MSB_FIRST=0, SAMPLE_EDGE=0, bits 1,0,0,0... (LSB-first 0x0001) -> spi_rdata = 0x0001.
- rst asserted after 20 bits of a 48-bit frame, CS held low to end of frame -> no spi_rvalid or spi_err, busy = 0; the next full frame is received correctly.
- Final SCK edge coincident with the synchronised CS rise -> 47 bits counted, spi_err pulses.
- 300 short frames with the macro defined -> err_cnt = 255.
